// File: rtl/cp0_reg.sv
// cp0_reg: MIPS CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC).
// Ports: clk/rst, MTC0 write (we/waddr/wsel/wdata), MFC0 read (raddr/rsel/rdata),
// exception bus (excepttype/exc_pc/is_in_delayslot/exc_badvaddr), int_i,
// register views cp0_status/cp0_cause/cp0_epc/cp0_badvaddr, timer_int.
// excepttype encoding: 0 none, 01 INT, 04 ADEL, 05 ADES, 08 SYS, 09 BP,
// 0a RI, 0c OV, 0e ERET; other nonzero values capture with ExcCode kept.
module cp0_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic [4:0]  excepttype,
  input  logic [31:0] exc_pc,
  input  logic        is_in_delayslot,
  input  logic [31:0] exc_badvaddr,
  input  logic [5:0]  int_i,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_badvaddr,
  output logic        timer_int
);

  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [7:0] A_BADV = {5'd8, 3'd0};
  localparam logic [7:0] A_CNT  = {5'd9, 3'd0};
  localparam logic [7:0] A_CMP  = {5'd11, 3'd0};
  localparam logic [7:0] A_STAT = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUS = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC  = {5'd14, 3'd0};

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        phase_q;
  logic        ti_q;
  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [1:0]  ip_sw_q;
  logic [5:0]  ip_hw_q;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;

  logic        exc_valid;
  logic        is_eret;
  logic        mtc0;
  logic [7:0]  wkey;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        code_known;
  logic [4:0]  code_arch;
  logic        addr_exc;

  assign exc_valid  = (excepttype != 5'd0);
  assign is_eret    = (excepttype == EXC_ERET);
  // MTC0 is dropped whenever an exception or ERET commits.
  assign mtc0       = we & ~exc_valid;
  assign wkey       = {waddr, wsel};
  assign wr_count   = mtc0 & (wkey == A_CNT);
  assign wr_compare = mtc0 & (wkey == A_CMP);
  assign wr_status  = mtc0 & (wkey == A_STAT);
  assign wr_cause   = mtc0 & (wkey == A_CAUS);
  assign wr_epc     = mtc0 & (wkey == A_EPC);

  always_comb begin
    code_known = 1'b1;
    code_arch  = 5'h00;
    addr_exc   = 1'b0;
    unique case (excepttype)
      EXC_INT:  code_arch = 5'h00;
      EXC_ADEL: begin
        code_arch = 5'h04;
        addr_exc  = 1'b1;
      end
      EXC_ADES: begin
        code_arch = 5'h05;
        addr_exc  = 1'b1;
      end
      EXC_SYS:  code_arch = 5'h08;
      EXC_BP:   code_arch = 5'h09;
      EXC_RI:   code_arch = 5'h0a;
      EXC_OV:   code_arch = 5'h0c;
      default:  code_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      compare_q  <= '0;
      phase_q    <= 1'b0;
      ti_q       <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      ip_hw_q <= int_i;

      if (wr_count) begin
        count_q <= wdata;
        phase_q <= 1'b0;
      end else begin
        phase_q <= ~phase_q;
        if (phase_q) count_q <= count_q + 32'd1;
      end

      if (wr_compare) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end

      if (exc_valid) begin
        if (is_eret) begin
          exl_q <= 1'b0;
        end else begin
          exl_q <= 1'b1;
          // Nested exceptions keep the original return point.
          if (!exl_q) begin
            epc_q <= is_in_delayslot ? exc_pc - 32'd4 : exc_pc;
            bd_q  <= is_in_delayslot;
          end
          if (code_known) exc_code_q <= code_arch;
          if (addr_exc) badvaddr_q <= exc_badvaddr;
        end
      end else begin
        if (wr_status) begin
          im_q  <= wdata[15:8];
          exl_q <= wdata[1];
          ie_q  <= wdata[0];
        end
        if (wr_cause) ip_sw_q <= wdata[9:8];
        if (wr_epc) epc_q <= wdata;
      end
    end
  end

  // BadVAddr is read-only from software.
  assign cp0_status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cp0_cause  = {bd_q, ti_q, 14'b0,
                       ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                       ip_sw_q, 1'b0, exc_code_q, 2'b0};
  assign cp0_epc      = epc_q;
  assign cp0_badvaddr = badvaddr_q;
  assign timer_int    = ti_q;

  always_comb begin
    rdata = '0;
    unique case ({raddr, rsel})
      A_BADV:  rdata = badvaddr_q;
      A_CNT:   rdata = count_q;
      A_CMP:   rdata = compare_q;
      A_STAT:  rdata = cp0_status;
      A_CAUS:  rdata = cp0_cause;
      A_EPC:   rdata = epc_q;
      default: rdata = '0;
    endcase
  end

endmodule
